imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side counterpart to the fetch path's instruction memory reader.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit instruction words.
- Writes each word to the instruction memory write port at sequential word-aligned byte addresses.
- Holds the CPU (busy) while a program image is being loaded.

Parameters:
- BASE_ADDR, 64'd0: byte address of the first instruction written; must be 4-byte aligned.
- MAX_WORDS, 1024: instruction memory capacity in words; larger loads are rejected.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- load_len  input  16  number of words to load; sampled on an accepted start.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  64  byte address of the write, equal to BASE_ADDR + 4*word_idx.
- wr_data  output  32  packed instruction word.
- busy  output  1  load in progress; the CPU stalls its PC while high.
- done  output  1  sticky completion flag; cleared by the next accepted start.
- error  output  1  sticky; last load was rejected or failed.
- words_written  output  16  count of words written in the current or last load.

Behaviour:
- Reset values: all outputs 0, state IDLE, byte count 0, word_idx 0, packing register 0. Reset mid-load aborts immediately with no further writes; partial memory contents are left as-is.
- States:
  - IDLE: in_ready=0. On start: if load_len==0, go to DONE (done=1) with no writes. If load_len>MAX_WORDS, go to DONE with error=1 and no writes. Otherwise go to RECV with busy=1, done=0, error=0, word_idx=0, words_written=0.
  - RECV: in_ready=1. A byte is accepted on a cycle with in_valid&in_ready.
    - Byte k (k=0..3) of a word lands in bits [8k+7:8k].
    - When the 4th byte is accepted, go to WRITE next cycle.
    - in_valid low leaves state and counters unchanged.
  - WRITE: a single cycle with in_ready=0, wr_en=1, wr_addr=BASE_ADDR+{word_idx,2'b00}, wr_data=packed word.
    - The same edge increments word_idx and words_written.
    - If word_idx+1==len, go to DONE (checksum variant: go to CKSUM). Otherwise return to RECV.
  - DONE: busy=0, done=1, in_ready=0. start behaves as in IDLE.
- start while busy (RECV/WRITE/CKSUM) is ignored.
- Throughput: 5 cycles per word at best (4 accept + 1 write). Latency from 4th byte accept to wr_en is 1 cycle.
- Address arithmetic is 64-bit unsigned, no wrap check beyond MAX_WORDS.
- wr_addr and wr_data are 0 whenever wr_en=0.
- busy deasserts in the same cycle done asserts.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: after the last WRITE, go to CKSUM with in_ready=1.
  - One extra byte is accepted and compared with the running XOR of all payload bytes.
  - Match: DONE with error=0. Mismatch: DONE with error=1; written words are not rolled back.
  - busy stays high through CKSUM.
- Undefined: no CKSUM state, no XOR register; DONE follows the last WRITE.

Decomposition:
- Package imem_loader_pkg:
  - state enum: IDLE, RECV, WRITE, CKSUM, DONE.
  - BYTES_PER_WORD=4.
  - LEN_W=16.
- Sub-module byte_packer: 2-bit byte count, 32-bit shift/insert register, word_full output, clear input. imem_loader instantiates it.

Test Plan:
- Reset low, start, load_len=2, bytes 8B,1F,00,91,E1,03,1F,AA with in_valid held high -> wr_en at addr 0x0 data 0x91001F8B, then 5 cycles later addr 0x4 data 0xAA1F03E1; done=1, busy=0, words_written=2.
- load_len=1, in_valid toggling every other cycle -> exactly 4 accepts, one wr_en, no byte dropped or duplicated.
- load_len=0 -> done=1 next cycle, no wr_en. load_len=MAX_WORDS+1 -> done=1, error=1, no wr_en.
- Assert reset after 2 bytes of word 3 -> outputs 0 immediately; new start with load_len=1 writes at BASE_ADDR.
- start pulsed during RECV -> ignored; word_idx and address sequence unchanged.
- Checksum build, load_len=1 bytes 01,02,03,04 then 04 -> error=0. Same load with trailing 05 -> error=1, word still written.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCksum,
`endif
    StDone
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream little-endian into a 32-bit word; word_full_o flags the push
// that completes the current word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic [1:0]  count_o,
  output logic        word_full_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  count_q, count_d;

  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    if (clear_i) begin
      word_d  = '0;
      count_d = '0;
    end else if (push_i) begin
      word_d[{count_q, 3'b000} +: 8] = data_i;
      count_d                        = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      word_q  <= '0;
      count_q <= '0;
    end else begin
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign word_o      = word_q;
  assign count_o     = count_q;
  assign word_full_o = push_i & ~clear_i & (count_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-stream program image into instruction memory, one 32-bit word per write.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [63:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_written
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic             error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       xor_q, xor_d;
`endif

  logic        pack_clear, pack_push, word_full;
  logic [31:0] pack_word;
  logic [1:0]  pack_count;
  logic        last_word;

  imem_loader_byte_packer u_byte_packer (
    .clk_i       (clk),
    .reset_i     (reset),
    .clear_i     (pack_clear),
    .push_i      (pack_push),
    .data_i      (in_data),
    .word_o      (pack_word),
    .count_o     (pack_count),
    .word_full_o (word_full)
  );

  assign last_word = ({1'b0, word_idx_q} + 17'd1) == {1'b0, len_q};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    error_d    = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    pack_clear = 1'b0;
    pack_push  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          word_idx_d = '0;
          pack_clear = 1'b1;
          if (load_len == '0) begin
            state_d = StDone;
            error_d = 1'b0;
          end else if (32'(load_len) > MAX_WORDS) begin
            state_d = StDone;
            error_d = 1'b1;
          end else begin
            state_d = StRecv;
            error_d = 1'b0;
            len_d   = load_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d   = '0;
`endif
          end
        end
      end
      StRecv: begin
        in_ready  = 1'b1;
        pack_push = in_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (in_valid) xor_d = xor_q ^ in_data;
`endif
        if (word_full) state_d = StWrite;
      end
      StWrite: begin
        wr_en      = 1'b1;
        pack_clear = 1'b1;
        word_idx_d = word_idx_q + 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StCksum;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StRecv;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCksum: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = StDone;
          // Written words stay in memory; only the flag reports the mismatch.
          error_d = (in_data != xor_q);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_idx_q <= '0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign wr_addr       = wr_en ? BASE_ADDR + {{(64 - LEN_W - 2){1'b0}}, word_idx_q, 2'b00} : '0;
  assign wr_data       = wr_en ? pack_word : '0;
  assign done          = (state_q == StDone);
  assign busy          = (state_q != StIdle) && (state_q != StDone);
  assign error         = error_q;
  assign words_written = word_idx_q;

  // Byte count is only observed through word_full.
  logic unused_count;
  assign unused_count = ^pack_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default BASE_ADDR/MAX_WORDS).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] load_len = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, busy, done, error;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] words_written;

  imem_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .load_len      (load_len),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;
  logic [63:0] log_addr [64];
  logic [31:0] log_data [64];
  int          log_cyc  [64];
  int n0, a0;
  logic [7:0] b2 [4];

  // Sampled at the rising edge, before state updates land.
  always @(posedge clk) begin
    if (!reset) begin
      cyc = cyc + 1;
      if (wr_en && wr_cnt < 64) begin
        log_addr[wr_cnt] = wr_addr;
        log_data[wr_cnt] = wr_data;
        log_cyc[wr_cnt]  = cyc;
        wr_cnt = wr_cnt + 1;
      end
      if (in_valid && in_ready) acc_cnt = acc_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept_wait", {63'd0, n < 20}, 64'd1);
    @(negedge clk);
  endtask

  task automatic end_load(input logic [7:0] x);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x);
    in_valid = 1'b0;
`else
    in_valid = 1'b0;
    in_data  = x;
    @(negedge clk);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_wr_addr", wr_addr, 64'd0);
    check("rst_wr_data", {32'd0, wr_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_words", {48'd0, words_written}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two words, valid held high
    n0 = wr_cnt;
    start = 1'b1; load_len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    check("t1_busy", {63'd0, busy}, 64'd1);
    check("t1_in_ready", {63'd0, in_ready}, 64'd1);
    check("t1_done_low", {63'd0, done}, 64'd0);
    send_byte(8'h8B); send_byte(8'h1F); send_byte(8'h00); send_byte(8'h91);
    check("t1_w0_en", {63'd0, wr_en}, 64'd1);
    check("t1_w0_addr", wr_addr, 64'h0);
    check("t1_w0_data", {32'd0, wr_data}, 64'h91001F8B);
    check("t1_w0_ready", {63'd0, in_ready}, 64'd0);
    send_byte(8'hE1); send_byte(8'h03); send_byte(8'h1F); send_byte(8'hAA);
    check("t1_w1_en", {63'd0, wr_en}, 64'd1);
    check("t1_w1_addr", wr_addr, 64'h4);
    check("t1_w1_data", {32'd0, wr_data}, 64'hAA1F03E1);
    end_load(8'h52);
    check("t1_done", {63'd0, done}, 64'd1);
    check("t1_busy_low", {63'd0, busy}, 64'd0);
    check("t1_words", {48'd0, words_written}, 64'd2);
    check("t1_error", {63'd0, error}, 64'd0);
    check("t1_idle_addr", wr_addr, 64'd0);
    check("t1_idle_data", {32'd0, wr_data}, 64'd0);
    check("t1_wr_count", 64'(wr_cnt - n0), 64'd2);
    check("t1_spacing", 64'(log_cyc[n0 + 1] - log_cyc[n0]), 64'd5);

    // One word, in_valid toggling
    n0 = wr_cnt; a0 = acc_cnt;
    b2[0] = 8'h11; b2[1] = 8'h22; b2[2] = 8'h33; b2[3] = 8'h44;
    start = 1'b1; load_len = 16'd1;
    @(negedge clk);
    start = 1'b0;
    check("t2_done_cleared", {63'd0, done}, 64'd0);
    check("t2_words_cleared", {48'd0, words_written}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      in_data = b2[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_data = 8'hFF;
      if (i < 3) @(negedge clk);
    end
    check("t2_wr_en", {63'd0, wr_en}, 64'd1);
    check("t2_wr_addr", wr_addr, 64'h0);
    check("t2_wr_data", {32'd0, wr_data}, 64'h44332211);
    check("t2_accepts", 64'(acc_cnt - a0), 64'd4);
    end_load(8'h44);
    check("t2_done", {63'd0, done}, 64'd1);
    check("t2_words", {48'd0, words_written}, 64'd1);
    check("t2_wr_count", 64'(wr_cnt - n0), 64'd1);

    // Zero-length and oversize loads
    n0 = wr_cnt;
    start = 1'b1; load_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    check("t3_len0_done", {63'd0, done}, 64'd1);
    check("t3_len0_busy", {63'd0, busy}, 64'd0);
    check("t3_len0_words", {48'd0, words_written}, 64'd0);
    check("t3_len0_error", {63'd0, error}, 64'd0);
    start = 1'b1; load_len = 16'd1025;
    @(negedge clk);
    start = 1'b0;
    check("t3_big_done", {63'd0, done}, 64'd1);
    check("t3_big_error", {63'd0, error}, 64'd1);
    check("t3_big_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("t3_no_writes", 64'(wr_cnt - n0), 64'd0);

    // MAX_WORDS is accepted; reset after 2 bytes of word 3
    start = 1'b1; load_len = 16'd1024;
    @(negedge clk);
    start = 1'b0;
    check("t4_max_busy", {63'd0, busy}, 64'd1);
    check("t4_max_error_clr", {63'd0, error}, 64'd0);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
    check("t4_words_before", {48'd0, words_written}, 64'd2);
    check("t4_writes_before", 64'(wr_cnt - n0), 64'd2);
    reset = 1'b1;
    #1;
    check("t4_rst_busy", {63'd0, busy}, 64'd0);
    check("t4_rst_ready", {63'd0, in_ready}, 64'd0);
    check("t4_rst_words", {48'd0, words_written}, 64'd0);
    check("t4_rst_wr_en", {63'd0, wr_en}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t4_no_more_writes", 64'(wr_cnt - n0), 64'd2);
    n0 = wr_cnt;
    start = 1'b1; load_len = 16'd1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    check("t4_new_addr", wr_addr, 64'h0);
    check("t4_new_data", {32'd0, wr_data}, 64'hD4C3B2A1);
    end_load(8'h04);
    check("t4_new_done", {63'd0, done}, 64'd1);
    check("t4_new_count", 64'(wr_cnt - n0), 64'd1);

    // start pulsed mid-load is ignored
    n0 = wr_cnt;
    start = 1'b1; load_len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    in_valid = 1'b0;
    start = 1'b1; load_len = 16'd1;
    @(negedge clk);
    start = 1'b0;
    check("t5_still_busy", {63'd0, busy}, 64'd1);
    check("t5_words_kept", {48'd0, words_written}, 64'd1);
    send_byte(8'h07); send_byte(8'h08);
    check("t5_w1_addr", wr_addr, 64'h4);
    check("t5_w1_data", {32'd0, wr_data}, 64'h08070605);
    end_load(8'h08);
    check("t5_done", {63'd0, done}, 64'd1);
    check("t5_words", {48'd0, words_written}, 64'd2);
    check("t5_count", 64'(wr_cnt - n0), 64'd2);
    check("t5_w0_addr", log_addr[n0], 64'h0);
    check("t5_w0_data", {32'd0, log_data[n0]}, 64'h04030201);

`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      n0 = wr_cnt;
      start = 1'b1; load_len = 16'd1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      check("t6_cksum_busy", {63'd0, busy}, 64'd1);
      send_byte((k == 0) ? 8'h04 : 8'h05);
      in_valid = 1'b0;
      check("t6_cksum_done", {63'd0, done}, 64'd1);
      check("t6_cksum_error", {63'd0, error}, 64'(k));
      check("t6_cksum_written", 64'(wr_cnt - n0), 64'd1);
      check("t6_cksum_data", {32'd0, log_data[n0]}, 64'h04030201);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
